// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the default
// bit period. Shared between the TX block and the future RX block.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 87;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity bit for an already-masked payload: XOR for even, inverted for odd.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the last count and
// wraps to 0 on that count or whenever restart is held.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tc
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_tc = (cnt_q == CNT_LAST);

  // Next count: restart or terminal count returns to zero, else increment.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_restart || o_tc) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register so the
// next byte can be queued while the current frame is on the line.
//
// Handshake: a byte is taken when i_Tx_DV and o_Tx_Ready are both high at a
// rising edge. o_Tx_Ready means the holding register is empty; a request
// while it is low is ignored and the byte is lost.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_par_q, hold_par_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        done_q, done_d;
  logic        accept, xfer, tc;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk     (i_Clock),
    .i_rst_n   (i_Rst_n),
    .i_restart (state_q == ST_IDLE),
    .o_tc      (tc)
  );

  assign accept      = i_Tx_DV && !hold_full_q;
  assign o_Tx_Ready  = !hold_full_q;
  assign o_Tx_Active = (state_q != ST_IDLE);
  assign o_Tx_Done   = done_q;

  // Frame sequencing, holding-register handoff and parity capture.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_par_d  = hold_par_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_idx_d   = bit_idx_q;
    done_d      = 1'b0;
    xfer        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          xfer    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tc) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tc) begin
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (tc) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tc) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = '0;
            done_d    = 1'b1;
            // A pending byte starts right away, no idle gap.
            if (hold_full_q) begin
              xfer    = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (xfer) begin
      shift_d = hold_data_q;
      par_d   = hold_par_q;
    end
    if (accept) begin
      hold_data_d = i_Tx_Byte & DATA_MASK;
      hold_par_d  = calc_parity(i_Tx_Byte & DATA_MASK, PARITY);
    end
    hold_full_d = accept | (hold_full_q & ~xfer);
  end

  // Line level for the current state; idle and stop are mark (1).
  always_comb begin
    o_Tx_Serial = 1'b1;
    case (state_q)
      ST_START:  o_Tx_Serial = 1'b0;
      ST_DATA:   o_Tx_Serial = shift_q[0];
      ST_PARITY: o_Tx_Serial = par_q;
      default:   o_Tx_Serial = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame in flight.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_par_q  <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_par_q  <= hold_par_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit_idx_q   <= bit_idx_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations side by side (8N1, 8E1, 8O1,
// 5N2), each with a stimulus process feeding an expected-byte queue and a
// line monitor that rebuilds every frame and checks it against a model.
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  int lanes_done = 0;

  task automatic check(input string nm, input int lane,
                       input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s lane%0d: got %0h expected %0h (cycle %0d)", nm, lane, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int DB    = (g == 3) ? 5 : 8;
    localparam int PM    = (g == 1) ? PAR_EVEN : ((g == 2) ? PAR_ODD : PAR_NONE);
    localparam int SB    = (g == 3) ? 2 : 1;
    localparam int NBITS = 1 + DB + ((PM != PAR_NONE) ? 1 : 0) + SB;
    localparam int FL    = NBITS * CPB;

    logic       rst_n = 1'b0;
    logic       dv    = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       serial, ready, active, done;

    logic [7:0]  exp_q[$];
    int          done_t[$];
    int          pos = -1;
    logic [63:0] smp = '0;
    logic        early = 1'b0;

    uart_tx_cfg #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB),
      .PARITY       (PM),
      .STOP_BITS    (SB)
    ) dut (
      .i_Clock     (clk),
      .i_Rst_n     (rst_n),
      .i_Tx_DV     (dv),
      .i_Tx_Byte   (din),
      .o_Tx_Ready  (ready),
      .o_Tx_Serial (serial),
      .o_Tx_Active (active),
      .o_Tx_Done   (done)
    );

    // Reference: per-cycle line waveform of one frame, bit 0 = first cycle.
    function automatic logic [63:0] ref_wave(input logic [7:0] b);
      logic [15:0] bits;
      logic [63:0] w;
      logic        p;
      int          n;
      bits = '1;
      bits[0] = 1'b0;
      n = 1;
      p = (PM == PAR_ODD);
      for (int i = 0; i < DB; i++) begin
        bits[n] = b[i];
        p = p ^ b[i];
        n++;
      end
      if (PM != PAR_NONE) bits[n] = p;
      w = '0;
      for (int c = 0; c < FL; c++) w[c] = bits[c / CPB];
      return w;
    endfunction

    // Monitor: capture FL cycles from each falling start edge, then expect Done.
    always @(negedge clk) begin
      if (!rst_n) begin
        pos   = -1;
        early = 1'b0;
      end else begin
        if (pos == FL) begin
          check("done_pulse", g, {63'd0, done & ~early}, 64'd1);
          done_t.push_back(cyc);
          check("frame_expected", g, 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            logic [7:0] b;
            b = exp_q.pop_front();
            check("frame_wave", g, smp, ref_wave(b));
          end
          pos = -1;
        end else if (pos >= 0) begin
          smp[pos] = serial;
          if (done) early = 1'b1;
          pos++;
        end else if (done) begin
          check("stray_done", g, 64'(done), 64'd0);
        end
        if (pos < 0 && serial == 1'b0) begin
          smp   = '0;
          early = 1'b0;
          pos   = 1;
        end
      end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      while (!ready && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (!ready) begin
        check("ready_timeout", g, 64'(ready), 64'd1);
      end else begin
        dv  = 1'b1;
        din = b;
        exp_q.push_back(b);
        @(negedge clk);
        dv  = 1'b0;
        din = 8'($urandom_range(0, 255));
      end
    endtask

    task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || pos >= 0 || active || !ready) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check("idle_reached", g, 64'(t < 3000), 64'd1);
    endtask

    initial begin
      logic [7:0] first;
      int t;
      first = (g == 0) ? 8'hA5 : ((g == 3) ? 8'hFF : 8'h07);

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_serial", g, 64'(serial), 64'd1);
      check("rst_ready",  g, 64'(ready),  64'd1);
      check("rst_active", g, 64'(active), 64'd0);
      check("rst_done",   g, 64'(done),   64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed frame with start-bit latency
      send(first);
      check("ready_after_accept", g, 64'(ready),  64'd0);
      check("serial_pre_start",   g, 64'(serial), 64'd1);
      @(negedge clk);
      check("start_bit_latency",  g, 64'(serial), 64'd0);
      check("active_in_frame",    g, 64'(active), 64'd1);
      check("ready_after_xfer",   g, 64'(ready),  64'd1);
      wait_idle();

      // Back-to-back frames
      done_t.delete();
      send(8'h55);
      send(8'hAA);
      check("ready_low_holding", g, 64'(ready), 64'd0);
      repeat (5) @(negedge clk);
      check("ready_still_low", g, 64'(ready), 64'd0);
      wait_idle();
      check("b2b_done_count", g, 64'(done_t.size()), 64'd2);
      if (done_t.size() == 2)
        check("b2b_done_gap", g, 64'(done_t[1] - done_t[0]), 64'(FL));

      // DV held high while the holding register is full
      send(8'($urandom_range(0, 255)));
      send(8'($urandom_range(0, 255)));
      dv  = 1'b1;
      din = 8'h3C;
      repeat (8) @(negedge clk);
      check("ready_low_dv_held", g, 64'(ready), 64'd0);
      dv = 1'b0;
      wait_idle();

      // Reset in the 13th cycle of a frame
      send(8'h00);
      t = 0;
      while (serial !== 1'b0 && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("abort_frame_started", g, 64'(serial), 64'd0);
      repeat (12) @(negedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      done_t.delete();
      #1;
      check("abort_serial", g, 64'(serial), 64'd1);
      check("abort_ready",  g, 64'(ready),  64'd1);
      check("abort_active", g, 64'(active), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("abort_no_done",   g, 64'(done_t.size()), 64'd0);
      check("abort_idle_line", g, 64'(serial), 64'd1);
      send(8'hC3);
      wait_idle();

      // Randomized traffic with random gaps, including zero-gap bursts
      for (int i = 0; i < 12; i++) begin
        send(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, FL + 4)) @(negedge clk);
      end
      wait_idle();
      lanes_done++;
    end
  end

  initial begin
    int t;
    t = 0;
    while (lanes_done < 4 && t < 40000) begin
      @(negedge clk);
      t++;
    end
    if (lanes_done < 4) begin
      compared++;
      mismatched++;
      $display("FAIL lanes_finished: got %0d expected 4", lanes_done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: clock cycles per bit period, legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0: parity mode, 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-005 SHALL have port i_Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_Rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port i_Tx_DV, input, 1 bit: byte-valid request.
REQ-008 SHALL have port i_Tx_Byte, input, 8 bits: payload; bits above DATA_BITS-1 are ignored.
REQ-009 SHALL have port o_Tx_Ready, output, 1 bit: holding register empty, so a byte can be accepted.
REQ-010 SHALL have port o_Tx_Serial, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port o_Tx_Active, output, 1 bit: high while a frame is on the line.
REQ-012 SHALL have port o_Tx_Done, output, 1 bit: one-cycle pulse per completed frame.

Function
REQ-013 SHALL accept a byte into a one-entry holding register when i_Tx_DV=1 and o_Tx_Ready=1 in the same cycle; i_Tx_DV while o_Tx_Ready=0 is ignored and the byte is dropped.
REQ-014 SHALL deassert o_Tx_Ready in the cycle after acceptance and reassert it in the cycle after the holding register moves into the shift register.
REQ-015 SHALL have FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the holding register is full.
- START -> DATA.
- DATA -> PARITY if PARITY!=0, else DATA -> STOP.
- PARITY -> STOP.
- STOP -> START if the holding register is full, else STOP -> IDLE.
REQ-016 SHALL hold every bit for exactly CLKS_PER_BIT cycles; state advances on the last count; the counter resets to 0 on each bit boundary.
REQ-017 SHALL drive the start bit 0 in the cycle after the transfer from IDLE, i.e. start-bit latency is 2 cycles from acceptance when idle.
REQ-018 SHALL send data LSB first, DATA_BITS bits.
REQ-019 SHALL compute the parity bit as XOR of the DATA_BITS data bits for even parity, and its inverse for odd parity; the value is captured at load time.
REQ-020 SHALL hold the stop level 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-021 SHALL set the frame length to (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-022 SHALL pulse o_Tx_Done for exactly one cycle, in the cycle after the last stop-bit cycle.
REQ-023 SHALL start a pending byte's start bit in the cycle immediately after the final stop cycle, with no idle gap and no cleanup state.
REQ-024 SHALL allow an accept and a hold-to-shift transfer in the same cycle without loss; the new byte is held and o_Tx_Ready stays 0.
REQ-025 SHALL drive o_Tx_Active = (state != IDLE).
REQ-026 SHALL size the bit counter as $clog2(CLKS_PER_BIT) bits and the bit index as 3 bits; there shall be no wrap beyond the terminal values.
REQ-027 SHALL drive o_Tx_Serial 1 in IDLE.

Reset
REQ-028 SHALL, while i_Rst_n=0, immediately force:
- o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0;
- state IDLE, counters 0, holding register empty.
REQ-029 SHALL abort a frame when reset arrives mid-frame, with no Done pulse; after release the block idles until a new i_Tx_DV.

Structure
REQ-030 SHALL place the FSM state enum, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the default CLKS_PER_BIT in shared package uart_pkg, reused by the future RX block.
REQ-031 SHALL use one sub-module, uart_baud_cnt (parametrised counter, restart input, terminal-count output).

Verification
REQ-032 SHALL cover CLKS_PER_BIT=4, 8N1, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, Done exactly 40 cycles after the start bit begins.
REQ-033 SHALL cover even parity, send 0x07 -> parity bit 1; odd parity, send 0x07 -> parity bit 0; frame 44 cycles.
REQ-034 SHALL cover 8N1, 0x55 then 0xAA presented while Ready -> no idle cycle between frames, two Done pulses 40 cycles apart, Ready low while holding.
REQ-035 SHALL cover DATA_BITS=5, STOP_BITS=2, send 0xFF -> only 5 ones after the start bit, 8 stop-high cycles, frame 32 cycles.
REQ-036 SHALL cover reset asserted at cycle 13 of a frame -> Serial=1 and Ready=1 immediately, no Done, and the next frame is correct.
REQ-037 SHALL cover i_Tx_DV held high while Ready=0 -> the extra byte is not sent.
